// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing plus helpers shared by the timing generator and its users.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 10;

    typedef logic [DEF_CW-1:0] vga_pos_t;

    function automatic int vga_h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int vga_v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: the generator drives it, renderers consume it.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          pix_tick;
    logic [CW-1:0] colPos;
    logic [CW-1:0] rowPos;
    logic          HSYNC;
    logic          VSYNC;
    logic          de;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_tick, colPos, rowPos, HSYNC, VSYNC, de, line_start, frame_start
    );

    modport slave (
        input pix_tick, colPos, rowPos, HSYNC, VSYNC, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_tick_div.sv
// Pixel-clock prescaler: one-clk tick every PIX_DIV enabled clocks; en=0 freezes the count.
module vga_tick_div #(
    parameter int PIX_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int            DW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);

    generate
        if (PIX_DIV < 1) begin : g_bad_div
            $error("vga_tick_div: PIX_DIV must be >= 1");
        end
    endgenerate

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        tick      = 1'b0;
        if (en) begin
            if (div_cnt_q == LAST) begin
                div_cnt_d = '0;
                tick      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters advanced by the prescaler tick, then a registered output stage
// presenting the pre-increment position with its sync/enable decodes and strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_DIV  = 1,
    parameter int CW       = DEF_CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    vga_timing_gen_if.master vo
);
    localparam int H_TOTAL = vga_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_width
            $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
        end
        if (PIX_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: PIX_DIV must be >= 1");
        end
    endgenerate

    // Inclusive sync windows keep every bound inside CW bits even when a porch ends at 2**CW.
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_ON    = HS_POL;
    localparam logic          VS_ON    = VS_POL;

    logic tick;

    vga_tick_div #(
        .PIX_DIV (PIX_DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic          tick_q, tick_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    always_comb begin
        hc_d   = hc_q;
        vc_d   = vc_q;
        col_d  = col_q;
        row_d  = row_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        de_d   = de_q;
        tick_d = 1'b0;
        ls_d   = 1'b0;
        fs_d   = 1'b0;
        if (tick) begin
            col_d  = hc_q;
            row_d  = vc_q;
            hs_d   = (hc_q >= HS_FIRST && hc_q <= HS_LAST) ? HS_ON : ~HS_ON;
            vs_d   = (vc_q >= VS_FIRST && vc_q <= VS_LAST) ? VS_ON : ~VS_ON;
            de_d   = (hc_q < H_ACT) && (vc_q < V_ACT);
            tick_d = 1'b1;
            ls_d   = (hc_q == '0);
            fs_d   = (hc_q == '0) && (vc_q == '0);
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q   <= '0;
            vc_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
            hs_q   <= ~HS_ON;
            vs_q   <= ~VS_ON;
            de_q   <= 1'b0;
            tick_q <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            col_q  <= col_d;
            row_q  <= row_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            tick_q <= tick_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign vo.pix_tick    = tick_q;
    assign vo.colPos      = col_q;
    assign vo.rowPos      = row_q;
    assign vo.HSYNC       = hs_q;
    assign vo.VSYNC       = vs_q;
    assign vo.de          = de_q;
    assign vo.line_start  = ls_q;
    assign vo.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, a tiny 16x12 raster, and a tiny PIX_DIV=2 inverted-polarity raster.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(10)) if_a ();
    vga_timing_gen_if #(.CW(10)) if_b ();
    vga_timing_gen_if #(.CW(10)) if_c ();

    vga_timing_gen dut_a (
        .clk (clk), .rst_n (rst_n), .en (en), .vo (if_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .HS_POL (1'b0), .VS_POL (1'b0), .PIX_DIV (1), .CW (10)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .en (en), .vo (if_b)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .HS_POL (1'b1), .VS_POL (1'b1), .PIX_DIV (2), .CW (10)
    ) dut_c (
        .clk (clk), .rst_n (rst_n), .en (en), .vo (if_c)
    );

    typedef struct {
        int sel;
        int k;
        int col;
        int row;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
        bit tk;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25:0] pack(int col, int row, bit hs, bit vs, bit de, bit ls, bit fs, bit tk);
        logic [9:0] c;
        logic [9:0] r;
        c = col[9:0];
        r = row[9:0];
        return {c, r, hs, vs, de, ls, fs, tk};
    endfunction

    function automatic logic [25:0] obs(int sel);
        case (sel)
            0: return {if_a.colPos, if_a.rowPos, if_a.HSYNC, if_a.VSYNC, if_a.de,
                       if_a.line_start, if_a.frame_start, if_a.pix_tick};
            1: return {if_b.colPos, if_b.rowPos, if_b.HSYNC, if_b.VSYNC, if_b.de,
                       if_b.line_start, if_b.frame_start, if_b.pix_tick};
            default: return {if_c.colPos, if_c.rowPos, if_c.HSYNC, if_c.VSYNC, if_c.de,
                             if_c.line_start, if_c.frame_start, if_c.pix_tick};
        endcase
    endfunction

    task automatic check_vec(string name, logic [25:0] act, logic [25:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got col=%0d row=%0d hs/vs/de/ls/fs/tk=%b, need col=%0d row=%0d hs/vs/de/ls/fs/tk=%b",
                     name, act[25:16], act[15:6], act[5:0], exp[25:16], exp[15:6], exp[5:0]);
        end else begin
            $display("ok   %s: col=%0d row=%0d flags=%b", name, act[25:16], act[15:6], act[5:0]);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic add(int sel, int k, int col, int row, bit hs, bit vs, bit de, bit ls, bit fs, bit tk);
        vec_t v;
        v.sel = sel; v.k = k; v.col = col; v.row = row;
        v.hs = hs; v.vs = vs; v.de = de; v.ls = ls; v.fs = fs; v.tk = tk;
        tbl.push_back(v);
    endtask

    initial begin
        int hs_cnt;
        int hs_first;
        int hs_last;
        int ls_k[2];
        int ls_n;
        int fb_k[2];
        int fb_n;
        int fc_k[2];
        int fc_n;
        string nm;

        hs_cnt = 0; hs_first = -1; hs_last = -1;
        ls_n = 0; fb_n = 0; fc_n = 0;
        ls_k[0] = -1; ls_k[1] = -1; fb_k[0] = -1; fb_k[1] = -1; fc_k[0] = -1; fc_k[1] = -1;

        // k = posedges since reset release with en=1; PIX_DIV=1 shows pixel k-1 after edge k.
        //  sel k     col  row hs vs de ls fs tk
        add(0, 1,    0,   0,  1, 1, 1, 1, 1, 1);
        add(0, 641,  640, 0,  1, 1, 0, 0, 0, 1);
        add(0, 657,  656, 0,  0, 1, 0, 0, 0, 1);
        add(0, 752,  751, 0,  0, 1, 0, 0, 0, 1);
        add(0, 753,  752, 0,  1, 1, 0, 0, 0, 1);
        add(0, 800,  799, 0,  1, 1, 0, 0, 0, 1);
        add(0, 801,  0,   1,  1, 1, 1, 1, 0, 1);
        add(0, 8800, 799, 10, 1, 1, 0, 0, 0, 1);
        add(0, 8801, 0,   11, 1, 1, 1, 1, 0, 1);
        add(1, 1,    0,   0,  1, 1, 1, 1, 1, 1);
        add(1, 9,    8,   0,  1, 1, 0, 0, 0, 1);
        add(1, 11,   10,  0,  0, 1, 0, 0, 0, 1);
        add(1, 13,   12,  0,  0, 1, 0, 0, 0, 1);
        add(1, 14,   13,  0,  1, 1, 0, 0, 0, 1);
        add(1, 17,   0,   1,  1, 1, 1, 1, 0, 1);
        add(1, 97,   0,   6,  1, 1, 0, 1, 0, 1);
        add(1, 129,  0,   8,  1, 0, 0, 1, 0, 1);
        add(1, 160,  15,  9,  1, 0, 0, 0, 0, 1);
        add(1, 161,  0,   10, 1, 1, 0, 1, 0, 1);
        add(1, 192,  15,  11, 1, 1, 0, 0, 0, 1);
        add(1, 193,  0,   0,  1, 1, 1, 1, 1, 1);
        // PIX_DIV=2: pixel p appears after edge 2(p+1); odd edges hold with strobes low.
        add(2, 1,    0,   0,  0, 0, 0, 0, 0, 0);
        add(2, 2,    0,   0,  0, 0, 1, 1, 1, 1);
        add(2, 3,    0,   0,  0, 0, 1, 0, 0, 0);
        add(2, 4,    1,   0,  0, 0, 1, 0, 0, 1);
        add(2, 22,   10,  0,  1, 0, 0, 0, 0, 1);
        add(2, 23,   10,  0,  1, 0, 0, 0, 0, 0);
        add(2, 28,   13,  0,  0, 0, 0, 0, 0, 1);
        add(2, 258,  0,   8,  0, 1, 0, 1, 0, 1);
        add(2, 322,  0,   10, 0, 0, 0, 1, 0, 1);
        add(2, 386,  0,   0,  0, 0, 1, 1, 1, 1);

        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) tick();
        check_vec("reset_a", obs(0), pack(0, 0, 1, 1, 0, 0, 0, 0));
        check_vec("reset_c_pol1", obs(2), pack(0, 0, 0, 0, 0, 0, 0, 0));

        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= 8801; k++) begin
            tick();
            foreach (tbl[i]) begin
                if (tbl[i].k == k) begin
                    nm = $sformatf("vec_dut%0d_k%0d", tbl[i].sel, k);
                    check_vec(nm, obs(tbl[i].sel),
                              pack(tbl[i].col, tbl[i].row, tbl[i].hs, tbl[i].vs,
                                   tbl[i].de, tbl[i].ls, tbl[i].fs, tbl[i].tk));
                end
            end
            if (k <= 800 && if_a.HSYNC == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(if_a.colPos);
                hs_last = int'(if_a.colPos);
            end
            if (if_a.line_start && ls_n < 2) begin ls_k[ls_n] = k; ls_n++; end
            if (if_b.frame_start && fb_n < 2) begin fb_k[fb_n] = k; fb_n++; end
            if (if_c.frame_start && fc_n < 2) begin fc_k[fc_n] = k; fc_n++; end
        end

        check_int("hsync_low_count", hs_cnt, 96);
        check_int("hsync_first_col", hs_first, 656);
        check_int("hsync_last_col", hs_last, 751);
        check_int("line_period_a", ls_k[1] - ls_k[0], 800);
        check_int("frame_period_b", fb_k[1] - fb_k[0], 192);
        check_int("frame_period_c_div2", fc_k[1] - fc_k[0], 384);

        // en low for 37 clk while dut_a is presenting (300,11)
        for (int i = 0; i < 1000 && int'(if_a.colPos) != 300; i++) tick();
        check_vec("en_hold_entry", obs(0), pack(300, 11, 1, 1, 1, 0, 0, 1));
        en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick();
            check_vec($sformatf("en_low_%0d", i), obs(0), pack(300, 11, 1, 1, 1, 0, 0, 0));
        end
        en = 1'b1;
        tick();
        check_vec("en_resume", obs(0), pack(301, 11, 1, 1, 1, 0, 0, 1));

        // Asynchronous reset mid-line at (500,11)
        for (int i = 0; i < 1000 && int'(if_a.colPos) != 500; i++) tick();
        check_vec("rst_entry", obs(0), pack(500, 11, 1, 1, 1, 0, 0, 1));
        rst_n = 1'b0;
        #1;
        check_vec("rst_async_a", obs(0), pack(0, 0, 1, 1, 0, 0, 0, 0));
        check_vec("rst_async_c", obs(2), pack(0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rst_n = 1'b1;
        tick();
        check_vec("rst_first_tick", obs(0), pack(0, 0, 1, 1, 1, 1, 1, 1));
        tick();
        check_vec("rst_second_tick", obs(0), pack(1, 0, 1, 1, 1, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
